// File: rtl/weight_loader.sv
// weight_loader: streams weight bytes over valid/ready into the 32-entry weight
// memory write port, starting at a range-checked base address.
// Optional feature: define WEIGHT_LOADER_CHECKSUM_EN to add the running byte-sum
// output `checksum`.
module weight_loader #(
    parameter int unsigned ADDR_W    = 13,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned MEM_DEPTH = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [5:0]        length,
    input  logic              abort,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err
`ifdef WEIGHT_LOADER_CHECKSUM_EN
    ,
    output logic [7:0]        checksum
`endif
);

    localparam int unsigned LEN_W = 6;
    localparam int unsigned CHK_W = ADDR_W + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] ptr;
    logic [LEN_W-1:0]  remaining;
    logic [CHK_W-1:0]  end_addr;
    logic              range_bad;
    logic              hs;

    // Command range check is done one bit wider than the address so it cannot wrap.
    assign end_addr  = CHK_W'(base_addr) + CHK_W'(length);
    assign range_bad = end_addr > CHK_W'(MEM_DEPTH);
    assign hs        = in_valid && in_ready;

    // Load sequencer: command acceptance, registered memory writes and status pulses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            ptr       <= '0;
            remaining <= '0;
            in_ready  <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
`ifdef WEIGHT_LOADER_CHECKSUM_EN
            checksum  <= '0;
`endif
        end else begin
            mem_we <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (range_bad) begin
                            err <= 1'b1;
                        end else if (length == '0) begin
                            state <= FINISH;
                            done  <= 1'b1;
`ifdef WEIGHT_LOADER_CHECKSUM_EN
                            checksum <= '0;
`endif
                        end else begin
                            state     <= LOAD;
                            ptr       <= base_addr;
                            remaining <= length;
                            in_ready  <= 1'b1;
                            busy      <= 1'b1;
`ifdef WEIGHT_LOADER_CHECKSUM_EN
                            checksum  <= '0;
`endif
                        end
                    end
                end
                LOAD: begin
                    if (abort) begin
                        // A byte offered alongside abort is dropped.
                        state    <= IDLE;
                        in_ready <= 1'b0;
                        busy     <= 1'b0;
                    end else if (hs) begin
                        mem_we    <= 1'b1;
                        mem_addr  <= ptr;
                        mem_wdata <= in_data;
                        remaining <= remaining - LEN_W'(1);
`ifdef WEIGHT_LOADER_CHECKSUM_EN
                        checksum  <= checksum + 8'(in_data);
`endif
                        if (remaining == LEN_W'(1)) begin
                            // Pointer is left on the last address so it never leaves the memory.
                            state    <= FINISH;
                            done     <= 1'b1;
                            in_ready <= 1'b0;
                            busy     <= 1'b0;
                        end else begin
                            ptr <= ptr + ADDR_W'(1);
                        end
                    end
                end
                FINISH: begin
                    state <= IDLE;
                end
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_weight_loader.sv
// Testbench for weight_loader: directed cases plus randomized load commands,
// checked against expectations derived from the command/byte stream the bench drives.
module tb_weight_loader;

    localparam int unsigned ADDR_W = 13;
    localparam int unsigned DATA_W = 8;
    localparam int          DEPTH  = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [5:0]        length;
    logic              abort;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              busy;
    logic              done;
    logic              err;
`ifdef WEIGHT_LOADER_CHECKSUM_EN
    logic [7:0]        checksum;
`endif

    int total = 0;
    int bad   = 0;
    int last_sum = 0;

    weight_loader dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .base_addr (base_addr),
        .length    (length),
        .abort     (abort),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .busy      (busy),
        .done      (done),
        .err       (err)
`ifdef WEIGHT_LOADER_CHECKSUM_EN
        ,
        .checksum  (checksum)
`endif
    );

    initial begin
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_sum(input string tag, input int exp);
`ifdef WEIGHT_LOADER_CHECKSUM_EN
        check(tag, 32'(checksum), 32'(exp & 8'hFF));
`endif
    endtask

    // Issue one command from a negedge; returns at a negedge with inputs idle.
    // prob < 0 alternates in_valid starting high; fixed uses bytes 0x11,0x22,...
    task automatic run_load(input int base, input int len, input int prob,
                            input int abort_at, input bit poke_start, input bit fixed);
        int  idx     = 0;
        int  sum     = 0;
        int  cyc     = 0;
        bit  prev_hs = 1'b0;
        int  prev_d  = 0;
        bit  v;
        int  d;
        bit  do_abort;

        start     = 1'b1;
        base_addr = ADDR_W'(base);
        length    = 6'(len);
        @(negedge clk);
        start = 1'b0;

        if (base + len > DEPTH) begin
            check("rej_err", 32'(err), 1);
            check("rej_busy", 32'(busy), 0);
            check("rej_ready", 32'(in_ready), 0);
            check("rej_we", 32'(mem_we), 0);
            check("rej_done", 32'(done), 0);
            check_sum("rej_sum_hold", last_sum);
            @(negedge clk);
            check("rej_err_pulse", 32'(err), 0);
            check("rej_we2", 32'(mem_we), 0);
            check("rej_busy2", 32'(busy), 0);
            return;
        end

        if (len == 0) begin
            check("zero_done", 32'(done), 1);
            check("zero_we", 32'(mem_we), 0);
            check("zero_busy", 32'(busy), 0);
            check("zero_ready", 32'(in_ready), 0);
            check_sum("zero_sum", 0);
            last_sum = 0;
            @(negedge clk);
            check("zero_done_pulse", 32'(done), 0);
            check("zero_we2", 32'(mem_we), 0);
            return;
        end

        while (idx < len) begin
            check("load_ready", 32'(in_ready), 1);
            check("load_busy", 32'(busy), 1);
            check("load_done", 32'(done), 0);
            check("load_err", 32'(err), 0);
            check_sum("load_sum", sum);
            if (prev_hs) begin
                check("wr_we", 32'(mem_we), 1);
                check("wr_addr", 32'(mem_addr), 32'(base + idx - 1));
                check("wr_data", 32'(mem_wdata), 32'(prev_d));
            end else begin
                check("idle_we", 32'(mem_we), 0);
                if (idx > 0) check("hold_addr", 32'(mem_addr), 32'(base + idx - 1));
            end

            if (prob < 0) v = (cyc % 2 == 0);
            else          v = ($urandom_range(0, 99) < prob);
            d = fixed ? ((8'h11 * (idx + 1)) & 8'hFF) : int'($urandom_range(0, 255));
            do_abort  = v && (abort_at == idx);
            in_valid  = v;
            in_data   = DATA_W'(d);
            abort     = do_abort;
            start     = poke_start && ($urandom_range(0, 3) == 0);
            base_addr = ADDR_W'($urandom);
            length    = 6'($urandom_range(0, 32));
            @(negedge clk);
            in_valid = 1'b0;
            abort    = 1'b0;
            start    = 1'b0;

            if (do_abort) begin
                check("abort_ready", 32'(in_ready), 0);
                check("abort_busy", 32'(busy), 0);
                check("abort_we", 32'(mem_we), 0);
                check("abort_done", 32'(done), 0);
                check_sum("abort_sum", sum);
                last_sum = sum;
                return;
            end

            prev_hs = v;
            if (v) begin
                prev_d = d;
                sum    = sum + d;
                idx++;
            end
            cyc++;
        end

        // Last write and done land together.
        check("last_we", 32'(mem_we), 1);
        check("last_addr", 32'(mem_addr), 32'(base + len - 1));
        check("last_data", 32'(mem_wdata), 32'(prev_d));
        check("last_done", 32'(done), 1);
        check("last_ready", 32'(in_ready), 0);
        check("last_busy", 32'(busy), 0);
        check_sum("final_sum", sum);
        last_sum = sum;

        // Offer a byte and abort while finishing: neither may have any effect.
        in_valid = 1'b1;
        in_data  = 8'hEE;
        abort    = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        abort    = 1'b0;
        check("post_done", 32'(done), 0);
        check("post_we", 32'(mem_we), 0);
        check("post_ready", 32'(in_ready), 0);
        check("post_addr_hold", 32'(mem_addr), 32'(base + len - 1));
        check("post_data_hold", 32'(mem_wdata), 32'(prev_d));
        check_sum("post_sum_hold", sum);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ready"}, 32'(in_ready), 0);
        check({tag, "_we"}, 32'(mem_we), 0);
        check({tag, "_addr"}, 32'(mem_addr), 0);
        check({tag, "_data"}, 32'(mem_wdata), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_done"}, 32'(done), 0);
        check({tag, "_err"}, 32'(err), 0);
        check_sum({tag, "_sum"}, 0);
    endtask

    initial begin
        int base;
        int len;
        int ab;

        reset = 1'b0; start = 1'b0; base_addr = '0; length = '0;
        abort = 1'b0; in_valid = 1'b0; in_data = '0;
        repeat (3) @(negedge clk);
        check_all_zero("rst");
        reset = 1'b1;
        @(negedge clk);

        // Directed cases
        run_load(0, 4, 100, -1, 1'b0, 1'b1);
        run_load(28, 4, -1, -1, 1'b0, 1'b0);
        run_load(30, 4, 100, -1, 1'b0, 1'b0);
        run_load(5, 0, 100, -1, 1'b0, 1'b0);
        run_load(8, 6, 100, 2, 1'b0, 1'b0);
        run_load(0, 32, 100, -1, 1'b1, 1'b0);
        run_load(8191, 1, 100, -1, 1'b0, 1'b0);
        run_load(31, 1, 100, -1, 1'b0, 1'b0);

        // Reset in the middle of a load after two bytes
        start = 1'b1; base_addr = 13'd0; length = 6'd6;
        @(negedge clk);
        start = 1'b0;
        in_valid = 1'b1; in_data = 8'hA5;
        @(negedge clk);
        in_data = 8'h5A;
        @(negedge clk);
        check("pre_rst_we", 32'(mem_we), 1);
        check("pre_rst_addr", 32'(mem_addr), 1);
        #2 reset = 1'b0;
        #1 check_all_zero("midrst");
        @(negedge clk);
        check("midrst_we_held", 32'(mem_we), 0);
        reset = 1'b1;
        last_sum = 0;
        @(negedge clk);
        check("after_rst_we", 32'(mem_we), 0);
        check("after_rst_ready", 32'(in_ready), 0);
        in_valid = 1'b0;
        run_load(0, 4, 100, -1, 1'b0, 1'b0);

        // Randomized commands
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 9) == 0) base = int'($urandom_range(33, 8191));
            else                           base = int'($urandom_range(0, 31));
            len = int'($urandom_range(0, 32));
            ab  = (len > 0 && $urandom_range(0, 4) == 0) ? int'($urandom_range(0, len - 1)) : -1;
            run_load(base, len, int'($urandom_range(20, 100)), ab, $urandom_range(0, 1) == 1, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
